// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC selection, exception entry/return and an
// optional return-address stack enabled by the PC_SEQ_RAS_EN macro.
module pc_seq_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             PcReSetN,
  input  logic [2:0]       PcSel,
  input  logic             Stall,
  input  logic             Exc,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PcPlus4,
  output logic [WIDTH-1:0] EPC,
  output logic             AlignErr,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnder
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] FOUR   = WIDTH'(32'd4);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic             align_err_r;
  logic [WIDTH-1:0] pc_plus4_s;
  logic [WIDTH-1:0] jump_tgt_s;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] epc_nxt_s;
  logic             align_nxt_s;

`ifdef PC_SEQ_RAS_EN
  localparam int                PTR_W   = $clog2(RAS_DEPTH);
  localparam int                CNT_W   = $clog2(RAS_DEPTH) + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_sp_r;
  logic [CNT_W-1:0] ras_cnt_r;
  logic [CNT_W-1:0] ras_cnt_nxt_s;
  logic             ras_empty_r;
  logic             ras_full_r;
  logic             ras_under_r;
  logic             under_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] ras_top_s;

  assign ras_top_s = ras_mem_r[ras_sp_r - PTR_ONE];
`endif

  assign pc_plus4_s = pc_r + FOUR;
  assign jump_tgt_s = {pc_plus4_s[WIDTH-1:28], Imm[25:0], 2'b00};

  // Next-PC / EPC selection with Exc over Stall over PcSel.
  always_comb begin
    pc_nxt_s    = pc_r;
    epc_nxt_s   = epc_r;
    align_nxt_s = 1'b0;
`ifdef PC_SEQ_RAS_EN
    under_nxt_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
`endif
    if (Exc) begin
      epc_nxt_s = pc_r;
      pc_nxt_s  = EXC_PC;
    end else if (Stall) begin
      pc_nxt_s = pc_r;
    end else begin
      case (PcSel)
        3'b000: pc_nxt_s = pc_plus4_s;
        3'b001: pc_nxt_s = pc_plus4_s + (Imm << 2'd2);
        3'b010: pc_nxt_s = jump_tgt_s;
        3'b011, 3'b100: begin
          if (Target[1:0] == 2'b00) begin
            pc_nxt_s = Target;
          end else begin
            pc_nxt_s    = EXC_PC;
            epc_nxt_s   = Target;
            align_nxt_s = 1'b1;
          end
        end
        3'b101: pc_nxt_s = epc_r;
        3'b110: begin
          pc_nxt_s = jump_tgt_s;
`ifdef PC_SEQ_RAS_EN
          push_s   = 1'b1;
`endif
        end
        3'b111: begin
`ifdef PC_SEQ_RAS_EN
          if (ras_cnt_r == {CNT_W{1'b0}}) begin
            pc_nxt_s    = pc_plus4_s;
            under_nxt_s = 1'b1;
          end else begin
            pc_nxt_s = ras_top_s;
            pop_s    = 1'b1;
          end
`else
          pc_nxt_s = pc_plus4_s;
`endif
        end
        default: pc_nxt_s = pc_plus4_s;
      endcase
    end
  end

  // PC, EPC and misalignment pulse registers.
  always_ff @(posedge Clk or negedge PcReSetN) begin
    if (!PcReSetN) begin
      pc_r        <= RST_PC;
      epc_r       <= {WIDTH{1'b0}};
      align_err_r <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      epc_r       <= epc_nxt_s;
      align_err_r <= align_nxt_s;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Occupancy saturates at RAS_DEPTH; a push while full overwrites the oldest slot.
  always_comb begin
    ras_cnt_nxt_s = ras_cnt_r;
    if (push_s) begin
      if (ras_cnt_r != CNT_MAX) begin
        ras_cnt_nxt_s = ras_cnt_r + CNT_ONE;
      end else begin
        ras_cnt_nxt_s = ras_cnt_r;
      end
    end else if (pop_s) begin
      ras_cnt_nxt_s = ras_cnt_r - CNT_ONE;
    end else begin
      ras_cnt_nxt_s = ras_cnt_r;
    end
  end

  // Stack pointer, count, status flags and underflow pulse.
  always_ff @(posedge Clk or negedge PcReSetN) begin
    if (!PcReSetN) begin
      ras_sp_r    <= {PTR_W{1'b0}};
      ras_cnt_r   <= {CNT_W{1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
      ras_under_r <= 1'b0;
    end else begin
      if (push_s) begin
        ras_sp_r <= ras_sp_r + PTR_ONE;
      end else if (pop_s) begin
        ras_sp_r <= ras_sp_r - PTR_ONE;
      end
      ras_cnt_r   <= ras_cnt_nxt_s;
      ras_empty_r <= (ras_cnt_nxt_s == {CNT_W{1'b0}});
      ras_full_r  <= (ras_cnt_nxt_s == CNT_MAX);
      ras_under_r <= under_nxt_s;
    end
  end

  // Return-address storage.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      ras_mem_r[ras_sp_r] <= pc_plus4_s;
    end
  end

  assign RasEmpty = ras_empty_r;
  assign RasFull  = ras_full_r;
  assign RasUnder = ras_under_r;
`else
  assign RasEmpty = 1'b1;
  assign RasFull  = 1'b0;
  assign RasUnder = 1'b0;
`endif

  assign PC       = pc_r;
  assign PcPlus4  = pc_plus4_s;
  assign EPC      = epc_r;
  assign AlignErr = align_err_r;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit with a queue-based reference model checked every cycle.
module tb_pc_seq_unit;

  logic        Clk = 1'b0;
  logic        PcReSetN;
  logic [2:0]  PcSel;
  logic        Stall;
  logic        Exc;
  logic [31:0] Imm;
  logic [31:0] Target;
  logic [31:0] PC;
  logic [31:0] PcPlus4;
  logic [31:0] EPC;
  logic        AlignErr;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasUnder;

  pc_seq_unit dut (
    .Clk(Clk), .PcReSetN(PcReSetN), .PcSel(PcSel), .Stall(Stall), .Exc(Exc),
    .Imm(Imm), .Target(Target), .PC(PC), .PcPlus4(PcPlus4), .EPC(EPC),
    .AlignErr(AlignErr), .RasEmpty(RasEmpty), .RasFull(RasFull), .RasUnder(RasUnder)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_align;
  bit          m_under;
  logic [31:0] m_ras [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] jump_addr(input logic [31:0] pp4, input logic [31:0] idx);
    return (pp4 & 32'hF000_0000) | ((idx & 32'h03FF_FFFF) * 32'd4);
  endfunction

  // Reference model: what the registers must hold after each edge.
  always @(posedge Clk or negedge PcReSetN) begin : model
    logic [31:0] pp4;
    if (!PcReSetN) begin
      m_pc = 32'h0000_3000; m_epc = 32'd0; m_align = 1'b0; m_under = 1'b0;
      m_ras.delete();
    end else begin
      pp4 = m_pc + 32'd4;
      m_align = 1'b0; m_under = 1'b0;
      if (Exc) begin
        m_epc = m_pc; m_pc = 32'h0000_4180;
      end else if (!Stall) begin
        case (PcSel)
          3'd0: m_pc = pp4;
          3'd1: m_pc = pp4 + Imm * 32'd4;
          3'd2: m_pc = jump_addr(pp4, Imm);
          3'd3, 3'd4: begin
            if (Target % 32'd4 == 32'd0) m_pc = Target;
            else begin m_epc = Target; m_pc = 32'h0000_4180; m_align = 1'b1; end
          end
          3'd5: m_pc = m_epc;
          3'd6: begin
            m_pc = jump_addr(pp4, Imm);
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() == 4) void'(m_ras.pop_front());
            m_ras.push_back(pp4);
`endif
          end
          default: begin
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() == 0) begin m_pc = pp4; m_under = 1'b1; end
            else m_pc = m_ras.pop_back();
`else
            m_pc = pp4;
`endif
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check32("pc",     PC,       m_pc);
      check32("pcp4",   PcPlus4,  m_pc + 32'd4);
      check32("epc",    EPC,      m_epc);
      check32("align",  {31'd0, AlignErr}, {31'd0, m_align});
      check32("under",  {31'd0, RasUnder}, {31'd0, m_under});
      check32("empty",  {31'd0, RasEmpty}, {31'd0, m_ras.size() == 0});
      check32("full",   {31'd0, RasFull},  {31'd0, m_ras.size() == 4});
    end
  end

  task automatic step(input logic [2:0] sel, input logic st, input logic ex,
                      input logic [31:0] im, input logic [31:0] tg);
    PcSel = sel; Stall = st; Exc = ex; Imm = im; Target = tg;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    PcReSetN = 1'b0; PcSel = 3'd0; Stall = 1'b0; Exc = 1'b0; Imm = 32'd0; Target = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    check32("rst_pc", PC, 32'h0000_3000);
    check32("rst_empty", {31'd0, RasEmpty}, 32'd1);
    #2 PcReSetN = 1'b1;
    chk_en = 1'b1;
    check32("rel_pc", PC, 32'h0000_3000);

    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0); check32("seq1", PC, 32'h0000_3004);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0); check32("seq2", PC, 32'h0000_3008);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0); check32("seq3", PC, 32'h0000_300C);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0); check32("seq4", PC, 32'h0000_3010);

    step(3'd1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0); check32("br_back", PC, 32'h0000_300C);
    step(3'd1, 1'b0, 1'b0, 32'h0000_0004, 32'd0); check32("br_fwd", PC, 32'h0000_3020);

    step(3'd1, 1'b1, 1'b0, 32'h0000_0004, 32'd0); check32("stall_pc", PC, 32'h0000_3020);
    step(3'd2, 1'b1, 1'b1, 32'h0000_0004, 32'd0);
    check32("exc_pc", PC, 32'h0000_4180);
    check32("exc_epc", EPC, 32'h0000_3020);
    step(3'd5, 1'b0, 1'b0, 32'd0, 32'd0); check32("eret", PC, 32'h0000_3020);

    step(3'd3, 1'b0, 1'b0, 32'd0, 32'h0000_3402);
    check32("mis_pc", PC, 32'h0000_4180);
    check32("mis_epc", EPC, 32'h0000_3402);
    check32("mis_pulse", {31'd0, AlignErr}, 32'd1);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("mis_clr", {31'd0, AlignErr}, 32'd0);
    check32("mis_next", PC, 32'h0000_4184);
    step(3'd4, 1'b0, 1'b0, 32'd0, 32'h0000_3401);
    check32("mis4_pulse", {31'd0, AlignErr}, 32'd1);
    step(3'd4, 1'b1, 1'b0, 32'd0, 32'h0000_3401);
    check32("stall_nopulse", {31'd0, AlignErr}, 32'd0);
    check32("stall_hold", PC, 32'h0000_4180);

    step(3'd3, 1'b0, 1'b0, 32'd0, 32'h0000_5000); check32("jr", PC, 32'h0000_5000);
    step(3'd4, 1'b0, 1'b0, 32'd0, 32'hA000_0000); check32("abs", PC, 32'hA000_0000);
    step(3'd2, 1'b0, 1'b0, 32'hFC00_0040, 32'd0); check32("jmp", PC, 32'hA000_0100);

    step(3'd4, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC); check32("top_p4", PcPlus4, 32'd0);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("wrap", PC, 32'd0);
    check32("wrap_flag", {31'd0, AlignErr}, 32'd0);

`ifdef PC_SEQ_RAS_EN
    step(3'd4, 1'b0, 1'b0, 32'd0, 32'h0000_1000);
    for (int i = 0; i < 5; i++) begin
      step(3'd6, 1'b0, 1'b0, 32'h0000_0800 + 32'h40 * i, 32'd0);
      check32("call_pc", PC, 32'h0000_2000 + 32'h100 * i);
    end
    check32("ras_full", {31'd0, RasFull}, 32'd1);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0); check32("ret1", PC, 32'h0000_2304);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0); check32("ret2", PC, 32'h0000_2204);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0); check32("ret3", PC, 32'h0000_2104);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0); check32("ret4", PC, 32'h0000_2004);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("ret5_pc", PC, 32'h0000_2008);
    check32("ret5_under", {31'd0, RasUnder}, 32'd1);
    check32("ret5_empty", {31'd0, RasEmpty}, 32'd1);
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("under_clr", {31'd0, RasUnder}, 32'd0);
`else
    step(3'd6, 1'b0, 1'b0, 32'h0000_0010, 32'd0); check32("call_as_jmp", PC, 32'h0000_0040);
    step(3'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("ret_as_seq", PC, 32'h0000_0044);
    check32("tie_under", {31'd0, RasUnder}, 32'd0);
    check32("tie_empty", {31'd0, RasEmpty}, 32'd1);
    check32("tie_full", {31'd0, RasFull}, 32'd0);
`endif

    PcSel = 3'd3; Target = 32'h0000_5000;
    #2 PcReSetN = 1'b0;
    #1;
    check32("async_pc", PC, 32'h0000_3000);
    check32("async_epc", EPC, 32'd0);
    @(posedge Clk);
    #3 PcReSetN = 1'b1;
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0); check32("post_rst", PC, 32'h0000_3004);

    @(posedge Clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
